// File: rtl/axis_fifo_ram.sv
// Simple dual-port memory: synchronous write, asynchronous read.
// Maps onto distributed RAM; contents are never reset.
module axis_fifo_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_drop_fifo.sv
// FWFT FIFO between an unthrottled stream source and a stallable AXI4-Stream sink.
// Beats arriving while full (with no pop that cycle) are dropped and counted.
module axis_drop_fifo #(
    parameter int AXIS_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_count,
    input  logic                       clear_overflow
);

    localparam int PTR_WIDTH = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam logic [PTR_WIDTH-1:0] DEPTH_COUNT = PTR_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_WIDTH-1:0] count_reg, count_next;
    logic                 overflow_reg, overflow_next;
    logic [CNT_WIDTH-1:0] drop_count_reg, drop_count_next;

    logic empty, full, push, pop, drop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_COUNT);
    assign pop   = !empty && m_axis_tready;
    // A pop frees the slot this cycle, so a full buffer can still take a beat.
    assign push  = s_axis_tvalid && (!full || pop);
    assign drop  = s_axis_tvalid && full && !pop;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        overflow_next   = overflow_reg;
        drop_count_next = drop_count_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end

        // A drop coinciding with a clear restarts the tally at one.
        if (drop) begin
            overflow_next = 1'b1;
            if (clear_overflow) begin
                drop_count_next = CNT_WIDTH'(1);
            end else if (drop_count_reg != '1) begin
                drop_count_next = drop_count_reg + 1'b1;
            end
        end else if (clear_overflow) begin
            overflow_next   = 1'b0;
            drop_count_next = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            drop_count_reg <= drop_count_next;
        end
    end

    axis_fifo_ram #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_DEPTH_LOG2)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]),
        .rd_data (m_axis_tdata)
    );

    assign m_axis_tvalid = !empty;
    assign fifo_count    = count_reg;
    assign overflow      = overflow_reg;
    assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_axis_drop_fifo.sv
// Scoreboard bench for axis_drop_fifo: a reference queue tracks accepted beats,
// occupancy and the drop flag/counter, and is compared against the DUT every cycle.
module tb_axis_drop_fifo;

    localparam int DW    = 24;
    localparam int LOG2  = 4;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << LOG2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [LOG2:0]   fifo_count;
    logic            overflow;
    logic [CW-1:0]   drop_count;
    logic            clear_overflow;

    logic [DW-1:0]   sb_q[$];
    logic            exp_ovf;
    logic [CW-1:0]   exp_drops;
    int              err_cnt = 0;
    int              chk_cnt = 0;

    always #5 aclk = ~aclk;

    axis_drop_fifo #(
        .AXIS_DATA_WIDTH (DW),
        .FIFO_DEPTH_LOG2 (LOG2),
        .CNT_WIDTH       (CW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, update it, cross the edge,
    // then check the registered state.
    task automatic tick();
        bit popped, pushed, dropped;
        popped = 0; pushed = 0; dropped = 0;
        #1;
        if (aresetn) begin
            check("tvalid", m_axis_tvalid, (sb_q.size() != 0));
            if (sb_q.size() != 0 && m_axis_tready) begin
                check("tdata", m_axis_tdata, sb_q[0]);
                popped = 1;
            end
            if (s_axis_tvalid) begin
                if (sb_q.size() < DEPTH || popped) pushed = 1;
                else dropped = 1;
            end
            if (popped) void'(sb_q.pop_front());
            if (pushed) sb_q.push_back(s_axis_tdata);
            if (dropped) begin
                exp_ovf = 1'b1;
                if (clear_overflow) exp_drops = 1;
                else if (exp_drops != '1) exp_drops = exp_drops + 1'b1;
            end else if (clear_overflow) begin
                exp_ovf   = 1'b0;
                exp_drops = '0;
            end
            $display("beat in_v=%0b in=0x%0h rdy=%0b pop=%0b push=%0b drop=%0b occ=%0d",
                     s_axis_tvalid, s_axis_tdata, m_axis_tready, popped, pushed, dropped, sb_q.size());
        end else begin
            sb_q.delete();
            exp_ovf   = 1'b0;
            exp_drops = '0;
        end
        @(posedge aclk);
        #1;
        check("fifo_count", fifo_count, sb_q.size());
        check("overflow", overflow, exp_ovf);
        check("drop_count", drop_count, exp_drops);
    endtask

    task automatic drain(input int budget);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        check("drain_empty", fifo_count, 0);
        m_axis_tready = 1'b0;
    endtask

    initial begin
        aresetn        = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        m_axis_tready  = 1'b0;
        clear_overflow = 1'b0;
        exp_ovf        = 1'b0;
        exp_drops      = '0;

        // Reset
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drops", drop_count, 0);
        aresetn = 1'b1;

        // Fall-through with stall
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h000001;
        tick();
        s_axis_tvalid = 1'b0;
        check("ft_valid", m_axis_tvalid, 1);
        check("ft_data", m_axis_tdata, 24'h000001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ft_hold_valid", m_axis_tvalid, 1);
            check("ft_hold_data", m_axis_tdata, 24'h000001);
        end
        check("ft_count1", fifo_count, 1);
        m_axis_tready = 1'b1;
        tick();
        check("ft_count0", fifo_count, 0);
        m_axis_tready = 1'b0;

        // Fill past full
        for (int i = 0; i < 20; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(32'h10 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        check("fill_count", fifo_count, 16);
        check("fill_ovf", overflow, 1);
        check("fill_drops", drop_count, 4);

        // Push and pop together while full
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h0000AA;
        m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        check("full_pp_count", fifo_count, 16);
        check("full_pp_drops", drop_count, 4);
        drain(40);

        // Clear alone, then clear coincident with a drop
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_drops", drop_count, 0);
        for (int i = 0; i < DEPTH; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(32'h100 + i);
            tick();
        end
        clear_overflow = 1'b1;
        s_axis_tdata   = 24'h0000EE;
        tick();
        clear_overflow = 1'b0;
        s_axis_tvalid  = 1'b0;
        check("clrdrop_ovf", overflow, 1);
        check("clrdrop_drops", drop_count, 1);
        drain(40);

        // Streaming with random backpressure and a reset mid-stream
        for (int b = 0; b < 100; b++) begin
            if (b == 50) begin
                aresetn       = 1'b0;
                s_axis_tvalid = 1'b0;
                tick();
                aresetn = 1'b1;
                check("midrst_valid", m_axis_tvalid, 0);
                check("midrst_count", fifo_count, 0);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(32'h5000 + b);
            m_axis_tready = (sb_q.size() >= DEPTH - 2) ? 1'b1 : ($urandom_range(0, 9) < 7);
            tick();
        end
        drain(40);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axis_drop_fifo.md
# axis_drop_fifo

Buffers the unthrottled AXI4-Stream produced by the AXI-Lite-to-stream writer and re-emits it as a proper AXI4-Stream master with `tready` backpressure. The input side has no `tready`: every valid beat is either stored or, when the buffer is full, dropped and counted. Sits directly downstream of the writer and upstream of any consumer that can stall.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 24: stream data width, input and output.
- `FIFO_DEPTH_LOG2`, 4: log2 of buffer depth (depth = 16). Legal range 1..12.
- `CNT_WIDTH`, 16: width of the drop counter.

Ports:
- `aclk`, in, 1: single clock.
- `aresetn`, in, 1: reset, synchronous, active-low.
- `s_axis_tdata`, in, `AXIS_DATA_WIDTH`: input beat data.
- `s_axis_tvalid`, in, 1: input beat valid. There is no `tready`; the block must accept or drop the beat in this cycle.
- `m_axis_tdata`, out, `AXIS_DATA_WIDTH`: output beat data.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tready`, in, 1: downstream ready.
- `fifo_count`, out, `FIFO_DEPTH_LOG2+1`: current occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky, set when any beat is dropped.
- `drop_count`, out, `CNT_WIDTH`: number of dropped beats, saturating.
- `clear_overflow`, in, 1: single-cycle pulse that clears `overflow` and `drop_count`.

## Operation
- Storage: DEPTH-entry circular buffer. Write and read pointers are `FIFO_DEPTH_LOG2+1` bits wide and wrap naturally. `fifo_count = wr_ptr - rd_ptr`.
- Empty when `fifo_count == 0`. Full when `fifo_count == DEPTH`.
- Push: `s_axis_tvalid` high and (not full, or pop in the same cycle). The beat is written at `wr_ptr`, and `wr_ptr` increments.
- Drop: `s_axis_tvalid` high, full, and no pop in the same cycle. Memory and pointers are unchanged. `overflow` is set to 1. `drop_count` increments and saturates at all-ones.
- Pop: `m_axis_tvalid & m_axis_tready`. `rd_ptr` increments.
- Output is first-word-fall-through: `m_axis_tvalid = (fifo_count != 0)` and `m_axis_tdata = mem[rd_ptr]`.
- `m_axis_tdata` and `m_axis_tvalid` stay stable while `tvalid=1` and `tready=0`.
- Push and pop in the same cycle at any occupancy (including full): both take effect, `fifo_count` is unchanged, no drop.
- Push while empty: no same-cycle bypass. The beat appears on the output the next cycle.
- `clear_overflow` without a drop in the same cycle: `overflow` goes to 0 and `drop_count` to 0 the next cycle.
- `clear_overflow` with a drop in the same cycle: the event wins. `overflow` becomes 1 and `drop_count` becomes 1.
- Reset mid-operation: all buffered data is discarded. The next cycle after reset shows empty.

## Timing
- Reset values, in the cycle after `aresetn` is sampled low:
  - `wr_ptr = rd_ptr = 0`, `fifo_count = 0`, `m_axis_tvalid = 0`.
  - `overflow = 0`, `drop_count = 0`.
  - `m_axis_tdata` is don't-care while `m_axis_tvalid = 0`; the bench must not check it.
- Memory contents are not reset.
- Latency: a beat pushed at edge N is visible on `m_axis` after edge N, i.e. valid in cycle N+1 when the buffer was empty.
- Throughput: 1 beat/cycle sustained when `m_axis_tready = 1`.
- `fifo_count`, `overflow` and `drop_count` are registered and reflect the state after the last edge.
- All outputs are glitch-free functions of registers. `m_axis_tdata` is an asynchronous read of registered memory at the registered `rd_ptr`.

## Structure
- No shared package is needed. Depth is derived locally as `1 << FIFO_DEPTH_LOG2`.
- One sub-module: `axis_fifo_ram`, a simple dual-port memory with synchronous write, asynchronous read, and parameters `DATA_WIDTH` and `ADDR_WIDTH`. It is inferable as distributed RAM.
- Pointers, count, flags and the counter live in `axis_drop_fifo`. Target size is about 150 lines of RTL total.

## Test plan
All scenarios use the default parameters (DEPTH = 16).
- **Reset:** after 3 cycles of `aresetn=0`, expect `fifo_count=0`, `m_axis_tvalid=0`, `overflow=0`, `drop_count=0`.
- **Fall-through:** push 0x000001 with `m_axis_tready=0`. Expect `m_axis_tvalid=1` and `tdata=0x000001` one cycle later, held stable for 5 stalled cycles. Then raise `tready`; expect `fifo_count` 1→0.
- **Fill and overflow:** with `tready=0`, push 20 beats 0x10..0x23. Expect `fifo_count=16`, `overflow=1`, `drop_count=4`. Drain; expect exactly 0x10..0x1F in order.
- **Full with simultaneous push and pop:** at `fifo_count=16`, push 0xAA with `tready=1`. Expect no drop, `fifo_count` stays 16, and 0xAA is read last after draining.
- **Clear vs drop:** with `drop_count=4`, pulse `clear_overflow` alone; expect 0/0. Pulse it again coincident with a drop; expect `overflow=1`, `drop_count=1`.
- **Streaming and reset mid-operation:** 100 back-to-back beats with random `tready` (about 70% high) and occupancy kept below full. Expect an in-order scoreboard match. Assert reset at beat 50; expect empty the next cycle and correct resumption afterward.
